uart_tx_port: RTL and testbench
===============================

// Module: uart_tx_port
// PURPOSE
//   Memory-mapped serial output device; the output-side counterpart to the keyboard input device.
//   The CPU store path writes bytes into an 8-entry FIFO. The block serialises them as 8N1 on txd.
//   It exposes a 16-bit status word to the memory-mapping read mux.
//   It pulses an interrupt request when the transmitter drains.
// PARAMETERS
//   DIVISOR    217   clock cycles per bit (25 MHz / 115200); legal range 2..65535
//   FIFO_AW    3     FIFO address width; depth = 2**FIFO_AW = 8
//   IRQ_INDEX  4'd2  value driven on txIrqIndex
// PORTS
//   clk          in   1   system clock; all state on posedge
//   rst          in   1   asynchronous reset, active-low
//   wrData       in   1   strobe: push wrValue[7:0] into FIFO this cycle
//   wrCtrl       in   1   strobe: control write; wrValue[0]=1 clears overflow flag
//   wrValue      in   16  store data (ExCalResult); bits [15:8] ignored for wrData
//   statusData   out  16  {8'b0, count[3:0], 1'b0, overflow, txIdle, notFull}
//   txd          out  1   serial line; idle high
//   txIrq        out  1   one-cycle interrupt request pulse
//   txIrqIndex   out  4   constant IRQ_INDEX
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//     - txd=1, txIrq=0, FIFO emptied (count=0), overflow=0, FSM=IDLE, baud counter=0.
//     - statusData=16'h0003.
//     - Reset mid-frame aborts the frame; txd goes high immediately.
//   FIFO:
//     - Push on wrData when not full.
//     - When full, the push is accepted only if a pop occurs in the same cycle; otherwise the byte is dropped and overflow is set (sticky).
//     - Simultaneous push and pop: count is unchanged.
//     - count is 0..8; notFull = (count != 8).
//   Overflow:
//     - Cleared only by wrCtrl with wrValue[0]=1.
//     - If a drop and a clear occur in the same cycle, set wins.
//   FSM states: IDLE, START, DATA, STOP. The baud counter reloads to DIVISOR-1 on every bit boundary.
//     - IDLE: if FIFO non-empty, pop head into shift reg, txd<=0, go START.
//     - START: after DIVISOR cycles, txd<=shift[0], bitIdx<=0, go DATA.
//     - DATA: each DIVISOR cycles shift right, LSB first. After bit 7 has been held for DIVISOR cycles, txd<=1, go STOP.
//     - STOP: after DIVISOR cycles: if FIFO non-empty, pop and go START (no idle gap); else go IDLE with txIrq=1 for that one cycle.
//   Latency:
//     - wrData sampled at edge N into an empty FIFO with FSM IDLE -> txd falls at edge N+1.
//     - Every bit is exactly DIVISOR cycles; one frame is 10*DIVISOR cycles.
//   txIdle = (FSM==IDLE) && (count==0).
//   statusData is combinational from registered state; it has no read side effects.
//   wrData and wrCtrl in the same cycle: both take effect.
// STRUCTURE
//   Shared package uart_pkg: FSM state encoding (2-bit) and STATUS_* bit-position constants.
//     - The memory-mapping mux and the CPU test programs use the same constants.
//   Sub-module uart_tx_fifo: synchronous FIFO, parameter FIFO_AW, ports push/pop/din/dout/count/full/empty.
//     - Pointers wrap modulo depth; count width is FIFO_AW+1.
//   Top level contains the baud counter, the FSM, the shift register, the overflow flag and the IRQ logic.
// TESTING (bench uses DIVISOR=4)
//   1. Reset release, no writes -> txd=1, statusData=16'h0003, txIrq never pulses.
//   2. Write 8'hA5 at edge N -> txd low during cycles N+1..N+4; data bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high;
//      txIrq pulses once at edge N+41.
//   3. Write 3 bytes back-to-back -> three contiguous 40-cycle frames with no idle gap; exactly one txIrq, at the end.
//   4. Write 10 bytes in 10 consecutive cycles -> 9 accepted (one is popped at once), 1 dropped; overflow=1;
//      wrCtrl with wrValue=16'h0001 -> overflow=0.
//   5. Assert rst in the middle of data bit 3 -> txd=1 asynchronously, count=0;
//      after release, no residual frame is transmitted.
//   6. Writes while full, coincident with a STOP->START pop -> the write is accepted; count stays 8; overflow stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding and
// status-word bit positions used by the read mux and CPU test programs.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned STATUS_NOT_FULL  = 32'd0;
  localparam int unsigned STATUS_TX_IDLE   = 32'd1;
  localparam int unsigned STATUS_OVERFLOW  = 32'd2;
  localparam int unsigned STATUS_COUNT_LSB = 32'd4;
  localparam int unsigned STATUS_COUNT_W   = 32'd4;

  function automatic logic [15:0] pack_status(input logic [3:0] count,
                                              input logic       overflow,
                                              input logic       tx_idle,
                                              input logic       not_full);
    logic [15:0] s;
    s = 16'h0000;
    s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
    s[STATUS_OVERFLOW]                    = overflow;
    s[STATUS_TX_IDLE]                     = tx_idle;
    s[STATUS_NOT_FULL]                    = not_full;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. A push into a full FIFO is taken only
// when a pop happens in the same cycle; pointers wrap modulo the depth.
module uart_tx_fifo #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty
);

  localparam logic [FIFO_AW:0]   DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW-1:0] PTR_ONE = (FIFO_AW)'(32'd1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(32'd1);

  logic [7:0]         mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               do_push_s;
  logic               do_pop_s;

  assign full      = (count_q == DEPTH);
  assign empty     = (count_q == {(FIFO_AW + 1){1'b0}});
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter: FIFO-buffered store path, baud timing,
// status word for the read mux and a one-cycle interrupt when the line drains.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR   = 217,
  parameter int unsigned FIFO_AW   = 3,
  parameter logic [3:0]  IRQ_INDEX = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrData,
  input  logic        wrCtrl,
  input  logic [15:0] wrValue,
  output logic [15:0] statusData,
  output logic        txd,
  output logic        txIrq,
  output logic [3:0]  txIrqIndex
);

  localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 32'd1);

  tx_state_e        state_q;
  logic [15:0]      baud_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic             txd_q;
  logic             irq_q;
  logic             overflow_q;
  logic             overflow_d;

  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic [7:0]       fifo_dout_s;
  logic [FIFO_AW:0] fifo_count_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             baud_done_s;
  logic             tx_idle_s;
  logic [3:0]       count4_s;
  logic             unused_ok_s;

  uart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (wrValue[7:0]),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign baud_done_s = (baud_q == 16'd0);
  assign tx_idle_s   = (state_q == ST_IDLE) && fifo_empty_s;
  assign count4_s    = 4'(fifo_count_s);
  assign statusData  = pack_status(count4_s, overflow_q, tx_idle_s, !fifo_full_s);
  assign txd         = txd_q;
  assign txIrq       = irq_q;
  assign txIrqIndex  = IRQ_INDEX;
  assign unused_ok_s = ^wrValue[15:8];

  // Pop on leaving IDLE or at a STOP boundary, which lets a full FIFO still accept a write.
  always_comb begin
    fifo_pop_s = 1'b0;
    case (state_q)
      ST_IDLE: fifo_pop_s = !fifo_empty_s;
      ST_STOP: fifo_pop_s = baud_done_s && !fifo_empty_s;
      default: fifo_pop_s = 1'b0;
    endcase
    fifo_push_s = wrData && (!fifo_full_s || fifo_pop_s);
  end

  // Sticky overflow: a dropped byte beats a coincident clear.
  always_comb begin
    overflow_d = overflow_q;
    if (wrData && fifo_full_s && !fifo_pop_s) begin
      overflow_d = 1'b1;
    end else if (wrCtrl && wrValue[0]) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // Frame sequencer: every state holds its bit for DIVISOR cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= 16'd0;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            shift_q <= fifo_dout_s;
            txd_q   <= 1'b0;
            baud_q  <= BAUD_RELOAD;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done_s) begin
            txd_q     <= shift_q[0];
            bit_idx_q <= 3'd0;
            baud_q    <= BAUD_RELOAD;
            state_q   <= ST_DATA;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_done_s) begin
            baud_q <= BAUD_RELOAD;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_done_s) begin
            baud_q <= BAUD_RELOAD;
            if (!fifo_empty_s) begin
              shift_q <= fifo_dout_s;
              txd_q   <= 1'b0;
              state_q <= ST_START;
            end else begin
              irq_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: table vectors, directed frame-timing
// sequences and randomized traffic against a time-based line model.
module tb_uart_tx_port;

  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrData = 1'b0;
  logic        wrCtrl = 1'b0;
  logic [15:0] wrValue = 16'h0000;
  logic [15:0] statusData;
  logic        txd;
  logic        txIrq;
  logic [3:0]  txIrqIndex;

  always #5 clk = ~clk;

  uart_tx_port #(.DIVISOR(DIV), .FIFO_AW(3), .IRQ_INDEX(4'd2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wrData     (wrData),
    .wrCtrl     (wrCtrl),
    .wrValue    (wrValue),
    .statusData (statusData),
    .txd        (txd),
    .txIrq      (txIrq),
    .txIrqIndex (txIrqIndex)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int irq_cnt = 0;
  int last_irq_cyc = -1;

  // Reference model: a byte queue plus the time elapsed in the current frame.
  byte unsigned m_q[$];
  bit           m_busy;
  int           m_t;
  logic [7:0]   m_byte;
  bit           m_ovf;
  bit           m_irq;

  function automatic void model_reset();
    m_q.delete();
    m_busy = 1'b0;
    m_t    = 0;
    m_byte = 8'h00;
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
  endfunction

  function automatic void model_edge(bit wr, bit ctrl, logic [15:0] v);
    int pre;
    bit popped;
    bit drop;
    pre    = m_q.size();
    popped = 1'b0;
    m_irq  = 1'b0;
    if (!m_busy) begin
      if (pre > 0) begin
        m_byte = m_q.pop_front();
        m_busy = 1'b1;
        m_t    = 0;
        popped = 1'b1;
      end
    end else begin
      m_t++;
      if (m_t == FRAME) begin
        if (pre > 0) begin
          m_byte = m_q.pop_front();
          m_t    = 0;
          popped = 1'b1;
        end else begin
          m_busy = 1'b0;
          m_irq  = 1'b1;
        end
      end
    end
    drop = wr && (pre == 8) && !popped;
    if (wr && !drop) m_q.push_back(v[7:0]);
    if (drop) m_ovf = 1'b1;
    else if (ctrl && v[0]) m_ovf = 1'b0;
  endfunction

  function automatic logic m_txd();
    int slot;
    if (!m_busy) return 1'b1;
    slot = m_t / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[slot-1];
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_status();
    int n;
    n = m_q.size();
    return {8'h00, 4'(n), 1'b0, m_ovf, (!m_busy && n == 0), (n != 8)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(wrData, wrCtrl, wrValue);
    cyc++;
    #1;
    check("txd", {31'd0, txd}, {31'd0, m_txd()});
    check("txIrq", {31'd0, txIrq}, {31'd0, m_irq});
    check("status", {16'd0, statusData}, {16'd0, m_status()});
    if (txIrq) begin
      irq_cnt++;
      last_irq_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    wrData = 1'b0;
    wrCtrl = 1'b0;
    repeat (n) step();
  endtask

  task automatic write(input logic [7:0] b);
    wrData  = 1'b1;
    wrCtrl  = 1'b0;
    wrValue = {8'h5A, b};
    step();
    wrData  = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    wrData = 1'b0;
    wrCtrl = 1'b0;
    k = 0;
    while (!(statusData[1] === 1'b1 && !m_busy) && k < 1000) begin
      step();
      k++;
    end
    check(name, {31'd0, statusData[1]}, 32'd1);
  endtask

  typedef struct {
    bit          wr;
    bit          ctrl;
    logic [15:0] val;
    logic [15:0] exp_st;
    logic        exp_txd;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n0;
    int pct;
    int k;
    for (int i = 0; i < 10; i++) begin
      vecs[i].wr   = 1'b1;
      vecs[i].ctrl = 1'b0;
      vecs[i].val  = {8'hEE, 8'h05 + 8'(i)};
    end
    vecs[0].exp_st = 16'h0011; vecs[0].exp_txd = 1'b1;
    vecs[1].exp_st = 16'h0011; vecs[1].exp_txd = 1'b0;
    vecs[2].exp_st = 16'h0021; vecs[2].exp_txd = 1'b0;
    vecs[3].exp_st = 16'h0031; vecs[3].exp_txd = 1'b0;
    vecs[4].exp_st = 16'h0041; vecs[4].exp_txd = 1'b0;
    vecs[5].exp_st = 16'h0051; vecs[5].exp_txd = 1'b1;
    vecs[6].exp_st = 16'h0061; vecs[6].exp_txd = 1'b1;
    vecs[7].exp_st = 16'h0071; vecs[7].exp_txd = 1'b1;
    vecs[8].exp_st = 16'h0080; vecs[8].exp_txd = 1'b1;
    vecs[9].exp_st = 16'h0084; vecs[9].exp_txd = 1'b0;
    vecs[10] = '{wr: 1'b0, ctrl: 1'b1, val: 16'h0001, exp_st: 16'h0080, exp_txd: 1'b0};
    vecs[11] = '{wr: 1'b1, ctrl: 1'b0, val: 16'h0042, exp_st: 16'h0084, exp_txd: 1'b0};
    vecs[12] = '{wr: 1'b1, ctrl: 1'b1, val: 16'h0043, exp_st: 16'h0084, exp_txd: 1'b0};
    vecs[13] = '{wr: 1'b0, ctrl: 1'b1, val: 16'hFFFE, exp_st: 16'h0084, exp_txd: 1'b1};
    vecs[14] = '{wr: 1'b0, ctrl: 1'b1, val: 16'h0003, exp_st: 16'h0080, exp_txd: 1'b1};

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, txIrq}, 32'd0);
    check("rst_status", {16'd0, statusData}, 32'h0003);
    check("irq_index", {28'd0, txIrqIndex}, 32'd2);
    @(negedge clk);
    rst = 1'b1;

    // 1: idle line after reset
    irq_cnt = 0;
    idle(20);
    check("t1_no_irq", irq_cnt, 32'd0);

    // Table: fill, overflow, clear, set-beats-clear
    for (int i = 0; i < 15; i++) begin
      wrData  = vecs[i].wr;
      wrCtrl  = vecs[i].ctrl;
      wrValue = vecs[i].val;
      step();
      check($sformatf("vec%0d_status", i), {16'd0, statusData}, {16'd0, vecs[i].exp_st});
      check($sformatf("vec%0d_txd", i), {31'd0, txd}, {31'd0, vecs[i].exp_txd});
    end
    drain("vec_drain");

    // 2: single A5 frame, irq at N+41
    irq_cnt = 0;
    write(8'hA5);
    n0 = cyc;
    idle(45);
    check("t2_irq_count", irq_cnt, 32'd1);
    check("t2_irq_edge", last_irq_cyc, n0 + 41);

    // 3: three back-to-back frames, one irq at the end
    irq_cnt = 0;
    write(8'h3C);
    n0 = cyc;
    write(8'hC3);
    write(8'h81);
    idle(3 * FRAME + 5);
    check("t3_irq_count", irq_cnt, 32'd1);
    check("t3_irq_edge", last_irq_cyc, n0 + 1 + 3 * FRAME);

    // 5: asynchronous reset in the middle of data bit 3
    write(8'h00);
    n0 = cyc;
    write(8'h00);
    idle(17);
    check("t5_mid_bit3_low", {31'd0, txd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_async_txd", {31'd0, txd}, 32'd1);
    check("t5_async_status", {16'd0, statusData}, 32'h0003);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    irq_cnt = 0;
    idle(100);
    check("t5_no_residual_irq", irq_cnt, 32'd0);

    // 6: write while full, coincident with STOP->START pop
    for (int i = 0; i < 9; i++) write(8'h30 + 8'(i));
    k = 0;
    while (!(m_busy && m_t == FRAME - 1 && m_q.size() == 8) && k < 200) begin
      step();
      k++;
    end
    check("t6_reached_boundary", {31'd0, (m_busy && m_t == FRAME - 1)}, 32'd1);
    check("t6_full_before", {16'd0, statusData}, 32'h0080);
    write(8'h77);
    check("t6_full_after", {16'd0, statusData}, 32'h0080);
    drain("t6_drain");

    // Randomized traffic with varying write density
    for (int blk = 0; blk < 15; blk++) begin
      pct = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 30 : 85);
      for (int c = 0; c < 200; c++) begin
        wrData  = ($urandom_range(0, 99) < pct);
        wrCtrl  = ($urandom_range(0, 39) == 0);
        wrValue = 16'($urandom);
        step();
      end
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
